// File: rtl/alu_ctrl_pkg.sv
// Control codes shared between the ALU control block and the HI/LO multiply unit,
// plus the multiply unit's state encoding.
package alu_ctrl_pkg;

    localparam logic [5:0] SIG_MUL    = 6'b011001;
    localparam logic [5:0] SIG_MFHI   = 6'b010000;
    localparam logic [5:0] SIG_MFLO   = 6'b010010;
    localparam logic [5:0] SIG_COMMIT = 6'b111111;

    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mul_step.sv
// One combinational shift-add step of an unsigned multiplier: conditionally add the
// multiplicand into the upper half (keeping the carry), then shift the product right.
module mul_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] prod,
    input  logic [WIDTH-1:0]   mcand,
    input  logic               mbit,
    output logic [2*WIDTH-1:0] prod_next
);

    logic [WIDTH:0] sum;

    // NOTE: every signal written in always_comb is assigned on all paths, so no latch is inferred.
    always_comb begin
        sum       = {1'b0, prod[2*WIDTH-1:WIDTH]} + (mbit ? {1'b0, mcand} : '0);
        prod_next = {sum, prod[WIDTH-1:1]};
    end

endmodule

// File: rtl/mul_hilo_unit.sv
// Sequential unsigned multiplier with HI/LO result registers, driven one control code
// per cycle by the ALU control block (load, 32 steps, optional hold, then commit).
module mul_hilo_unit
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] dataOut,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    mul_state_e         state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_next;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;

    mul_step #(.WIDTH(WIDTH)) u_step (
        .prod      (prod),
        .mcand     (mcand),
        .mbit      (mplier[0]),
        .prod_next (prod_next)
    );

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Signal == SIG_MUL) begin
                        mcand  <= dataA;
                        mplier <= dataB;
                        prod   <= '0;
                        cnt    <= '0;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Anything other than a continued MUL hold (COMMIT included) abandons the multiply.
                    if (Signal == SIG_MUL) begin
                        prod   <= prod_next;
                        mplier <= mplier >> 1;
                        if (cnt == LAST_STEP) begin
                            cnt   <= '0;
                            state <= ST_WAIT;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (Signal == SIG_COMMIT) begin
                        hi    <= prod[2*WIDTH-1:WIDTH];
                        lo    <= prod[WIDTH-1:0];
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else if (Signal != SIG_MUL) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state == ST_RUN) || (state == ST_WAIT);
    end

    always_comb begin
        dataOut = '0;
        if (Signal == SIG_MFHI) begin
            dataOut = hi;
        end else if (Signal == SIG_MFLO) begin
            dataOut = lo;
        end
    end

endmodule

// File: tb/tb_mul_hilo_unit.sv
// Randomized scoreboard bench for mul_hilo_unit: stimulus pushes expected HI/LO on COMMIT,
// a negedge monitor pops one entry per done pulse; readback checks use a plain-arithmetic model.
module tb_mul_hilo_unit;

    localparam int W = 32;

    localparam logic [5:0] C_MUL    = 6'b011001;
    localparam logic [5:0] C_MFHI   = 6'b010000;
    localparam logic [5:0] C_MFLO   = 6'b010010;
    localparam logic [5:0] C_COMMIT = 6'b111111;
    localparam logic [5:0] C_ADD    = 6'b100000;
    localparam logic [5:0] C_NOP    = 6'b000000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [5:0]   sig;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] dout;
    logic         busy;
    logic         done;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t         sb_q[$];
    exp_t         mon_e;
    int           n_checks = 0;
    int           n_errors = 0;
    logic [W-1:0] model_hi;
    logic [W-1:0] model_lo;

    always #5 clk = ~clk;

    mul_hilo_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .Signal  (sig),
        .dataA   (a),
        .dataB   (b),
        .dataOut (dout),
        .busy    (busy),
        .done    (done)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        return 64'(x) * 64'(y);
    endfunction

    // Present a code for one rising edge; returns just after that edge.
    task automatic drive(input logic [5:0] s, input logic [W-1:0] da, input logic [W-1:0] db);
        sig = s;
        a   = da;
        b   = db;
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [5:0] s);
        sig = s;
        #1;
    endtask

    task automatic check_regs(input string tag);
        peek(C_MFHI);
        check({tag, "_hi"}, 64'(dout), 64'(model_hi));
        peek(C_MFLO);
        check({tag, "_lo"}, 64'(dout), 64'(model_lo));
        peek(C_NOP);
        check({tag, "_nop_out"}, 64'(dout), 64'd0);
    endtask

    function automatic logic [5:0] rand_other();
        logic [5:0] c;
        do c = 6'($urandom); while (c == C_MUL || c == C_COMMIT);
        return c;
    endfunction

    task automatic full_mul(input logic [W-1:0] x, input logic [W-1:0] y, input int extra, input bit scramble);
        logic [63:0] p;
        p = ref_mul(x, y);
        drive(C_MUL, x, y);
        for (int i = 0; i < 32; i++) begin
            check("busy_run", 64'(busy), 64'd1);
            drive(C_MUL, scramble ? $urandom : x, scramble ? $urandom : y);
        end
        check("busy_wait", 64'(busy), 64'd1);
        for (int i = 0; i < extra; i++) drive(C_MUL, $urandom, $urandom);
        sb_q.push_back('{hi: p[63:32], lo: p[31:0]});
        drive(C_COMMIT, $urandom, $urandom);
        model_hi = p[63:32];
        model_lo = p[31:0];
        check("busy_after_commit", 64'(busy), 64'd0);
        drive(C_MFLO, $urandom, $urandom);
        check("done_one_cycle", 64'(done), 64'd0);
        check("sb_drained", 64'(sb_q.size()), 64'd0);
        check_regs("mul");
    endtask

    task automatic abort_mul(input logic [W-1:0] x, input logic [W-1:0] y, input int steps, input logic [5:0] code);
        drive(C_MUL, x, y);
        for (int i = 0; i < steps; i++) drive(C_MUL, x, y);
        drive(code, x, y);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check_regs("abort");
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                check("spurious_done", 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("done_lo", 64'(dout), 64'(mon_e.lo));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] x;
        logic [W-1:0] y;
        sig      = C_NOP;
        a        = '0;
        b        = '0;
        model_hi = '0;
        model_lo = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check_regs("rst");
        rst_n = 1'b1;
        drive(C_NOP, '0, '0);

        drive(C_COMMIT, 32'd7, 32'd7);
        check("idle_commit_done", 64'(done), 64'd0);
        check("idle_commit_busy", 64'(busy), 64'd0);
        check_regs("idle_commit");

        full_mul(32'd3, 32'd5, 0, 1'b0);
        peek(C_MFLO);
        check("3x5_lo", 64'(dout), 64'd15);
        full_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0);
        peek(C_MFHI);
        check("max_hi", 64'(dout), 64'hFFFF_FFFE);

        full_mul(32'd20, 32'hE666_6669, 0, 1'b0);
        abort_mul(32'd9, 32'd9, 9, C_ADD);
        peek(C_MFHI);
        check("prior_hi", 64'(dout), 64'h12);
        peek(C_MFLO);
        check("prior_lo", 64'(dout), 64'h34);

        abort_mul(32'd11, 32'd13, 10, C_COMMIT);
        abort_mul(32'd11, 32'd13, 32, rand_other());

        drive(C_MUL, 32'd7, 32'd9);
        for (int i = 0; i < 20; i++) drive(C_MUL, 32'd7, 32'd9);
        rst_n = 1'b0;
        model_hi = '0;
        model_lo = '0;
        sb_q.delete();
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check_regs("midrst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        full_mul(32'd7, 32'd9, 0, 1'b0);
        peek(C_MFLO);
        check("7x9_lo", 64'(dout), 64'd63);

        full_mul($urandom, $urandom, 2, 1'b1);

        for (int n = 0; n < 20; n++) begin
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 5) == 0) x = '0;
            if ($urandom_range(0, 5) == 0) y = 32'hFFFF_FFFF;
            if ($urandom_range(0, 3) == 0)
                abort_mul(x, y, $urandom_range(0, 34), rand_other());
            else
                full_mul(x, y, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        check("final_sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
